// File: rtl/icache_refill_arbiter.sv
// Round-robin refill arbiter: one shared memory read port serving per-core I-cache line refills.
// Optional watchdog on stalled bursts is compiled in with `define REFILL_ARB_TIMEOUT_EN.

module icache_refill_arbiter_lane (
   input  logic clk,
   input  logic rst_n,
   input  logic sel,
   input  logic beat,
   input  logic done,
   input  logic err,
   output logic fill_valid,
   output logic fill_done,
   output logic fill_err
);
   // Strobes are registered so they line up with the registered fill_data/fill_word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_valid <= 1'b0;
         fill_done  <= 1'b0;
         fill_err   <= 1'b0;
      end else begin
         fill_valid <= sel & beat;
         fill_done  <= sel & done;
         fill_err   <= sel & err;
      end
   end
endmodule

module icache_refill_arbiter #(
   parameter int NUM_CORES      = 4,
   parameter int ADDR_SIZE      = 32,
   parameter int DATA_SIZE      = 32,
   parameter int WORDS_PER_LINE = 8
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic [NUM_CORES-1:0]                       req_valid,
   input  logic [NUM_CORES-1:0][ADDR_SIZE-1:0]        req_addr,
   output logic [NUM_CORES-1:0]                       fill_valid,
   output logic [$clog2(WORDS_PER_LINE)-1:0]          fill_word,
   output logic [DATA_SIZE-1:0]                       fill_data,
   output logic [NUM_CORES-1:0]                       fill_done,
   output logic [NUM_CORES-1:0]                       fill_err,
   output logic                                       mem_req,
   output logic [ADDR_SIZE-1:0]                       mem_addr,
   input  logic                                       mem_ack,
   input  logic                                       mem_rvalid,
   input  logic [DATA_SIZE-1:0]                       mem_rdata
);
   localparam int LINE_SIZE = WORDS_PER_LINE * DATA_SIZE / 8;
   localparam int OFF_BITS  = $clog2(LINE_SIZE);
   localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
   localparam int CORE_W    = $clog2(NUM_CORES);
   localparam logic [ADDR_SIZE-1:0] LINE_MASK = ~((ADDR_SIZE'(1) << OFF_BITS) - ADDR_SIZE'(1));
   localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, BURST, DONE} state_t;

   state_t                 state_q, state_d;
   logic [CORE_W-1:0]      rr_ptr_q, grant_q, pick;
   logic                   pick_found;
   logic [ADDR_SIZE-1:0]   addr_q;
   logic [WORD_BITS-1:0]   beat_cnt_q, fill_word_q;
   logic [DATA_SIZE-1:0]   fill_data_q;
   logic                   beat_cap, done_cap, err_cap, wd_expired;

   // First requester at or after rr_ptr, wrapping around the core list.
   always_comb begin
      pick       = rr_ptr_q;
      pick_found = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (!pick_found && req_valid[(int'(rr_ptr_q) + i) % NUM_CORES]) begin
            pick       = CORE_W'((int'(rr_ptr_q) + i) % NUM_CORES);
            pick_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      beat_cap = 1'b0;
      done_cap = 1'b0;
      err_cap  = 1'b0;
      case (state_q)
         IDLE:  if (pick_found) state_d = ISSUE;
         ISSUE: if (mem_ack) state_d = BURST;
         BURST: begin
            if (mem_rvalid) begin
               beat_cap = 1'b1;
               if (beat_cnt_q == LAST_WORD) begin
                  state_d  = DONE;
                  done_cap = 1'b1;
               end
            end else if (wd_expired) begin
               state_d  = DONE;
               done_cap = 1'b1;
               err_cap  = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         addr_q      <= '0;
         beat_cnt_q  <= '0;
         fill_word_q <= '0;
         fill_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && pick_found) begin
            grant_q <= pick;
            addr_q  <= req_addr[pick] & LINE_MASK;
         end
         if (state_q == ISSUE && mem_ack)
            beat_cnt_q <= '0;
         if (beat_cap) begin
            beat_cnt_q  <= beat_cnt_q + 1'b1;
            fill_word_q <= beat_cnt_q;
            fill_data_q <= mem_rdata;
         end
         if (state_q == DONE)
            rr_ptr_q <= (grant_q == CORE_W'(NUM_CORES - 1)) ? '0 : grant_q + 1'b1;
      end
   end

`ifdef REFILL_ARB_TIMEOUT_EN
   logic [7:0] wd_cnt_q;
   logic       wd_phase_q;

   assign wd_expired = (wd_cnt_q == 8'hFF);

   // Held at zero outside BURST, so entering BURST always starts a fresh count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q   <= '0;
         wd_phase_q <= 1'b0;
      end else if (state_q != BURST || mem_rvalid) begin
         wd_cnt_q   <= '0;
         wd_phase_q <= 1'b0;
      end else begin
         wd_phase_q <= ~wd_phase_q;
         if (wd_phase_q) wd_cnt_q <= wd_cnt_q + 8'd1;
      end
   end
`else
   assign wd_expired = 1'b0;
`endif

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
      icache_refill_arbiter_lane u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .sel        (grant_q == CORE_W'(i)),
         .beat       (beat_cap),
         .done       (done_cap),
         .err        (err_cap),
         .fill_valid (fill_valid[i]),
         .fill_done  (fill_done[i]),
         .fill_err   (fill_err[i])
      );
   end

   assign mem_req   = (state_q == ISSUE);
   assign mem_addr  = addr_q;
   assign fill_word = fill_word_q;
   assign fill_data = fill_data_q;
endmodule

// File: tb/tb_icache_refill_arbiter.sv
// Directed bench for icache_refill_arbiter: latency, round-robin order, stalls, gaps and reset abort.
module tb_icache_refill_arbiter;
   localparam int NC  = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int WPL = 8;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NC-1:0]         req_valid;
   logic [NC-1:0][AW-1:0] req_addr;
   logic [NC-1:0]         fill_valid, fill_done, fill_err;
   logic [2:0]            fill_word;
   logic [DW-1:0]         fill_data;
   logic                  mem_req, mem_ack, mem_rvalid;
   logic [AW-1:0]         mem_addr;
   logic [DW-1:0]         mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   int lat;

   always #5 clk = ~clk;

   icache_refill_arbiter #(
      .NUM_CORES(NC), .ADDR_SIZE(AW), .DATA_SIZE(DW), .WORDS_PER_LINE(WPL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
      .fill_valid(fill_valid), .fill_word(fill_word), .fill_data(fill_data),
      .fill_done(fill_done), .fill_err(fill_err), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_req"},    64'(mem_req),    0);
      chk({tag, "_mem_addr"},   64'(mem_addr),   0);
      chk({tag, "_fill_valid"}, 64'(fill_valid), 0);
      chk({tag, "_fill_word"},  64'(fill_word),  0);
      chk({tag, "_fill_data"},  64'(fill_data),  0);
      chk({tag, "_fill_done"},  64'(fill_done),  0);
      chk({tag, "_fill_err"},   64'(fill_err),   0);
   endtask

   // One full refill: waits (bounded) for mem_req, stalls the ack, returns beats with gaps.
   task automatic refill(input int core, input logic [AW-1:0] exp_addr, input int ack_dly,
                         input int gap, input logic [DW-1:0] base, output int lat_o);
      logic [NC-1:0] oh;
      oh = NC'(1) << core;
      lat_o = 1;
      tick();
      while (!mem_req && lat_o < 40) begin
         tick();
         lat_o++;
      end
      chk("mem_req_seen", 64'(mem_req), 1);
      chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
      for (int d = 0; d < ack_dly; d++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hDEAD_BEEF;
         tick();
         chk("req_hold", 64'(mem_req), 1);
         chk("addr_hold", 64'(mem_addr), 64'(exp_addr));
         chk("no_fill_in_issue", 64'(fill_valid), 0);
      end
      mem_rvalid = 1'b0;
      mem_ack    = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("req_drop", 64'(mem_req), 0);
      for (int k = 0; k < WPL; k++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = base + DW'(k);
         tick();
         mem_rvalid = 1'b0;
         chk("fill_valid", 64'(fill_valid), 64'(oh));
         chk("fill_word", 64'(fill_word), 64'(k));
         chk("fill_data", 64'(fill_data), 64'(base + DW'(k)));
         chk("fill_done", 64'(fill_done), (k == WPL-1) ? 64'(oh) : 64'(0));
         chk("fill_err", 64'(fill_err), 0);
         if (k != WPL-1) begin
            for (int g = 0; g < gap; g++) begin
               tick();
               chk("gap_no_fill", 64'(fill_valid | fill_done), 0);
            end
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      req_valid  = '0;
      req_addr   = '0;
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      rst_n      = 1'b1;
      #2 rst_n   = 1'b0;
      #1 chk_all_zero("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("idle_no_req", 64'(mem_req), 0);

      // Single refill from core 2, checking minimum latency and line alignment.
      req_valid   = 4'b0100;
      req_addr[2] = 32'h0000_1234;
      refill(2, 32'h0000_1220, 0, 0, 32'hA0, lat);
      chk("t1_latency", 64'(lat), 1);
      req_valid = '0;
      tick();
      chk("t1_idle_fv", 64'(fill_valid | fill_done), 0);
      chk("t1_idle_req", 64'(mem_req), 0);

      // Cores 0 and 3 together from reset, then again after the pointer wraps.
      do_reset();
      req_valid   = 4'b1001;
      req_addr[0] = 32'h0000_0040;
      req_addr[3] = 32'h8000_107C;
      refill(0, 32'h0000_0040, 0, 0, 32'h100, lat);
      req_valid[0] = 1'b0;
      refill(3, 32'h8000_1060, 0, 0, 32'h200, lat);
      chk("t2_back_to_back", 64'(lat), 2);
      req_valid[3] = 1'b0;
      tick();
      tick();
      req_valid = 4'b1001;
      refill(0, 32'h0000_0040, 0, 0, 32'h300, lat);
      req_valid[0] = 1'b0;
      refill(3, 32'h8000_1060, 0, 0, 32'h400, lat);
      req_valid = '0;
      tick();

      // All four continuously: order 0,1,2,3,0 with one idle cycle between refills.
      do_reset();
      req_addr[0] = 32'h0000_0000;
      req_addr[1] = 32'h0000_1000;
      req_addr[2] = 32'h0000_2000;
      req_addr[3] = 32'h0000_3000;
      req_valid   = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         refill(i % NC, AW'((i % NC) * 32'h1000), 0, 0, DW'(32'h1000 * (i + 1)), lat);
         chk("t3_latency", 64'(lat), (i == 0) ? 64'(1) : 64'(2));
      end
      req_valid = '0;
      tick();

      // Beats arriving with no transaction must be ignored.
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1234_5678;
      tick();
      tick();
      mem_rvalid = 1'b0;
      chk("idle_rvalid_fv", 64'(fill_valid), 0);
      chk("idle_rvalid_req", 64'(mem_req), 0);

      // Core 1 at top of address space, ack delayed 5 cycles, 3-cycle beat gaps.
      req_valid   = 4'b0010;
      req_addr[1] = 32'hFFFF_FFFF;
      refill(1, 32'hFFFF_FFE0, 5, 3, 32'h5500, lat);
      req_valid = '0;
      tick();

      // Reset after beat 4 aborts; core 2 is re-served from word 0.
      req_valid   = 4'b0100;
      req_addr[2] = 32'h0000_2468;
      tick();
      chk("t5_mem_req", 64'(mem_req), 1);
      chk("t5_mem_addr", 64'(mem_addr), 32'h0000_2460);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      for (int k = 0; k < 5; k++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 32'h700 + DW'(k);
         tick();
         mem_rvalid = 1'b0;
         chk("t5_word", 64'(fill_word), 64'(k));
      end
      rst_n = 1'b0;
      #1 chk_all_zero("abort");
      tick();
      rst_n = 1'b1;
      refill(2, 32'h0000_2460, 0, 0, 32'hB0, lat);
      chk("t5_latency", 64'(lat), 1);
      req_valid = '0;
      tick();
      chk("t5_idle", 64'(fill_valid | fill_done | fill_err), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
